// File: rtl/prbs_pkg.sv
// prbs_pkg: shared PRBS15 constants, checker FSM state type and the
// prediction helper used by the checker and the training generator.
// Polynomial is x^15 + x^14 + 1 with XNOR feedback, so the all-zero
// history is a legal (non-lockup) starting point.
package prbs_pkg;

    localparam int unsigned PRBS_SHIFT_WIDTH = 15;
    localparam int unsigned PRBS_SHIFT_TAP   = 13;
    localparam int unsigned LOSS_ERRORS      = 8;
    localparam int unsigned LOSS_WINDOW      = 128;

    typedef enum logic [1:0] {
        IDLE,
        SEED,
        VERIFY,
        LOCKED
    } prbs_state_e;

    // Next PRBS bit from a history whose bit 0 is the newest bit.
    function automatic logic prbs_predict(input logic [PRBS_SHIFT_WIDTH-1:0] h);
        return ~(h[PRBS_SHIFT_WIDTH-1] ^ h[PRBS_SHIFT_TAP]);
    endfunction

endpackage

// File: rtl/prbs_checker_if.sv
// prbs_checker_if: ADC sample stream, control and status bundle of the
// PRBS checker.
//   master: drives start/threshold/phase/sampleValid/sample, reads status
//   slave : the checker; reads the stream, drives locked/inverted/counts
interface prbs_checker_if #(
    parameter int ADC_WIDTH  = 16,
    parameter int OVERSAMPLE = 4
);
    localparam int PHASE_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

    logic                        start;
    logic signed [ADC_WIDTH-1:0] threshold;
    logic        [PHASE_W-1:0]   phase;
    logic                        sampleValid;
    logic signed [ADC_WIDTH-1:0] sample;
    logic                        locked;
    logic                        inverted;
    logic        [31:0]          errorCount;
    logic        [31:0]          bitCount;

    modport master (
        output start, threshold, phase, sampleValid, sample,
        input  locked, inverted, errorCount, bitCount
    );

    modport slave (
        input  start, threshold, phase, sampleValid, sample,
        output locked, inverted, errorCount, bitCount
    );

endinterface

// File: rtl/prbs_slicer.sv
// prbs_slicer: picks one valid sample out of every OVERSAMPLE group and
// slices it against a signed threshold.
//   clk_i, rst_ni      clock, async active-low reset
//   start_i            restarts the group counter; wins over a decision
//   sample_valid_i     qualifies sample_i
//   sample_i           signed ADC sample
//   threshold_i        signed slicer level (sample > threshold -> 1)
//   phase_i            index within the group used for the decision
//   invert_i           polarity applied to the decided bit
//   bitValid_o, bit_o  registered decision, one cycle after its sample
module prbs_slicer #(
    parameter int ADC_WIDTH  = 16,
    parameter int OVERSAMPLE = 4,
    parameter int PHASE_W    = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        start_i,
    input  logic                        sample_valid_i,
    input  logic signed [ADC_WIDTH-1:0] sample_i,
    input  logic signed [ADC_WIDTH-1:0] threshold_i,
    input  logic        [PHASE_W-1:0]   phase_i,
    input  logic                        invert_i,
    output logic                        bitValid_o,
    output logic                        bit_o
);

    logic [PHASE_W-1:0] cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic               bit_q, bit_d;

    always_comb begin
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        bit_d   = bit_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (sample_valid_i) begin
            if (cnt_q == phase_i) begin
                valid_d = 1'b1;
                bit_d   = (sample_i > threshold_i) ^ invert_i;
            end
            // OVERSAMPLE is a power of two, so natural wrap is modulo.
            cnt_d = (OVERSAMPLE == 1) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            valid_q <= 1'b0;
            bit_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            bit_q   <= bit_d;
        end
    end

    assign bitValid_o = valid_q;
    assign bit_o      = bit_q;

endmodule

// File: rtl/prbs_checker.sv
// prbs_checker: acquires lock on a PRBS15 (XNOR) training stream from an
// oversampled ADC and counts bit errors once locked.
//   adcClk     sole clock
//   adcResetN  asynchronous active-low reset
//   bus        prbs_checker_if.slave: start, threshold, phase, sampleValid,
//              sample in; locked, inverted, errorCount, bitCount out
// Optional feature: define PRBS_CHECKER_POLARITY_DETECT_EN to let the
// checker detect and correct an inverted stream (otherwise inverted = 0).
module prbs_checker
    import prbs_pkg::*;
#(
    parameter int ADC_WIDTH  = 16,
    parameter int OVERSAMPLE = 4,
    parameter int LOCK_COUNT = 32
) (
    input  logic          adcClk,
    input  logic          adcResetN,
    prbs_checker_if.slave bus
);

    localparam int PHASE_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int SEED_W  = $clog2(PRBS_SHIFT_WIDTH);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(LOSS_WINDOW);
    localparam int WERR_W  = $clog2(LOSS_ERRORS);

    logic bit_valid;
    logic bit_dec;

    prbs_state_e                 state_q, state_d;
    logic [PRBS_SHIFT_WIDTH-1:0] hist_q, hist_d;
    logic [SEED_W-1:0]           seed_q, seed_d;
    logic [MATCH_W-1:0]          match_q, match_d;
    logic [WIN_W-1:0]            win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]           win_err_q, win_err_d;
    logic [31:0]                 errorCount_q, errorCount_d;
    logic [31:0]                 bitCount_q, bitCount_d;
    logic                        locked_q, locked_d;
    logic                        inv_q, inv_d;
`ifdef PRBS_CHECKER_POLARITY_DETECT_EN
    logic [MATCH_W-1:0]          mis_q, mis_d;
`endif

    logic pred;
    logic mismatch;
    logic win_last;

    prbs_slicer #(
        .ADC_WIDTH  (ADC_WIDTH),
        .OVERSAMPLE (OVERSAMPLE),
        .PHASE_W    (PHASE_W)
    ) u_slicer (
        .clk_i          (adcClk),
        .rst_ni         (adcResetN),
        .start_i        (bus.start),
        .sample_valid_i (bus.sampleValid),
        .sample_i       (bus.sample),
        .threshold_i    (bus.threshold),
        .phase_i        (bus.phase),
        .invert_i       (inv_q),
        .bitValid_o     (bit_valid),
        .bit_o          (bit_dec)
    );

    assign pred     = prbs_predict(hist_q);
    assign mismatch = bit_dec ^ pred;
    assign win_last = (win_cnt_q == WIN_W'(LOSS_WINDOW - 1));

    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        seed_d       = seed_q;
        match_d      = match_q;
        win_cnt_d    = win_cnt_q;
        win_err_d    = win_err_q;
        errorCount_d = errorCount_q;
        bitCount_d   = bitCount_q;
        inv_d        = inv_q;
`ifdef PRBS_CHECKER_POLARITY_DETECT_EN
        mis_d        = mis_q;
`endif

        if (bus.start) begin
            state_d      = SEED;
            hist_d       = '0;
            seed_d       = '0;
            match_d      = '0;
            win_cnt_d    = '0;
            win_err_d    = '0;
            errorCount_d = '0;
            bitCount_d   = '0;
`ifdef PRBS_CHECKER_POLARITY_DETECT_EN
            mis_d        = '0;
`endif
        end else if (bit_valid) begin
            unique case (state_q)
                IDLE: ;
                SEED: begin
                    hist_d = {hist_q[PRBS_SHIFT_WIDTH-2:0], bit_dec};
                    if (seed_q == SEED_W'(PRBS_SHIFT_WIDTH - 1)) begin
                        seed_d  = '0;
                        state_d = VERIFY;
                    end else begin
                        seed_d = seed_q + 1'b1;
                    end
                end
                VERIFY: begin
                    hist_d = {hist_q[PRBS_SHIFT_WIDTH-2:0], bit_dec};
                    if (!mismatch) begin
`ifdef PRBS_CHECKER_POLARITY_DETECT_EN
                        mis_d = '0;
`endif
                        if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                            state_d   = LOCKED;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                        seed_d  = '0;
                        state_d = SEED;
`ifdef PRBS_CHECKER_POLARITY_DETECT_EN
                        // Counts failed verify attempts across reseeds; an
                        // inverted stream fails on the first verify bit.
                        if (mis_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            mis_d = '0;
                            inv_d = ~inv_q;
                        end else begin
                            mis_d = mis_q + 1'b1;
                        end
`endif
                    end
                end
                LOCKED: begin
                    // Once locked the reference free-runs on its own
                    // prediction so a flipped line bit is counted once
                    // instead of re-appearing at both feedback taps.
                    hist_d    = {hist_q[PRBS_SHIFT_WIDTH-2:0], pred};
                    win_cnt_d = win_last ? '0 : win_cnt_q + 1'b1;
                    win_err_d = win_last ? '0 : win_err_q;
                    if (bitCount_q != '1) begin
                        bitCount_d = bitCount_q + 32'd1;
                    end
                    if (mismatch) begin
                        if (errorCount_q != '1) begin
                            errorCount_d = errorCount_q + 32'd1;
                        end
                        if (win_err_q == WERR_W'(LOSS_ERRORS - 1)) begin
                            state_d   = SEED;
                            seed_d    = '0;
                            match_d   = '0;
                            win_cnt_d = '0;
                            win_err_d = '0;
                        end else if (!win_last) begin
                            win_err_d = win_err_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge adcClk or negedge adcResetN) begin
        if (!adcResetN) begin
            state_q      <= IDLE;
            hist_q       <= '0;
            seed_q       <= '0;
            match_q      <= '0;
            win_cnt_q    <= '0;
            win_err_q    <= '0;
            errorCount_q <= '0;
            bitCount_q   <= '0;
            locked_q     <= 1'b0;
            inv_q        <= 1'b0;
`ifdef PRBS_CHECKER_POLARITY_DETECT_EN
            mis_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            seed_q       <= seed_d;
            match_q      <= match_d;
            win_cnt_q    <= win_cnt_d;
            win_err_q    <= win_err_d;
            errorCount_q <= errorCount_d;
            bitCount_q   <= bitCount_d;
            locked_q     <= locked_d;
            inv_q        <= inv_d;
`ifdef PRBS_CHECKER_POLARITY_DETECT_EN
            mis_q        <= mis_d;
`endif
        end
    end

    assign bus.locked     = locked_q;
    assign bus.inverted   = inv_q;
    assign bus.errorCount = errorCount_q;
    assign bus.bitCount   = bitCount_q;

endmodule
